// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a receive FIFO that holds data plus error flags per frame.
// Define UART_RX_PARITY_EN to add the PARITY state and the parity_i decode.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVER_SAMPL = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [15:0]                   baud_div_i,
  input  logic [1:0]                    parity_i,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o,
  input  logic                          clr_overrun_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int SW = $clog2(OVER_SAMPL);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [SW-1:0] LAST_TICK = SW'(OVER_SAMPL - 1);
  localparam logic [SW-1:0] HALF_TICK = SW'(OVER_SAMPL / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [15:0]          baud_lat, baud_cnt;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] data_sh;
  logic                 tick, mid, half, fall;
  logic                 start_frame, data_go, push, par_en, pe_bit;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 pop, do_push;
  logic [EW-1:0]        head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;
  assign tick = (baud_cnt == baud_lat);
  assign mid  = tick && (sample_cnt == LAST_TICK);
  assign half = tick && (sample_cnt == HALF_TICK);

`ifdef UART_RX_PARITY_EN
  logic [1:0] parity_lat;
  logic       parity_err_r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_lat   <= 2'b00;
      parity_err_r <= 1'b0;
    end else if (start_frame) begin
      parity_lat   <= parity_i;
      parity_err_r <= 1'b0;
    end else if (state == PARITY && mid) begin
      // Mismatch flag: even expects XOR==bit, odd expects XOR!=bit.
      parity_err_r <= (^data_sh) ^ rx_sync ^ (parity_lat == 2'b10);
    end
  end

  assign par_en = (parity_lat == 2'b01) || (parity_lat == 2'b10);
  assign pe_bit = parity_err_r;
`else
  logic parity_unused;
  assign parity_unused = ^parity_i;
  assign par_en = 1'b0;
  assign pe_bit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    data_go     = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE:   if (fall) begin state_next = START; start_frame = 1'b1; end
      START:  if (half) begin
                if (!rx_sync) begin state_next = DATA; data_go = 1'b1; end
                else state_next = IDLE;
              end
      DATA:   if (mid && bit_cnt == LAST_BIT) state_next = par_en ? PARITY : STOP;
      PARITY: if (mid) state_next = STOP;
      STOP:   if (mid) begin push = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
    // Disable wins over everything, including a stop sample in the same cycle.
    if (!en_i) begin
      state_next  = IDLE;
      start_frame = 1'b0;
      data_go     = 1'b0;
      push        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_lat   <= '0;
      baud_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      data_sh    <= '0;
    end else if (start_frame) begin
      baud_lat   <= baud_div_i;
      baud_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (state == IDLE) begin
      baud_cnt   <= '0;
      sample_cnt <= '0;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
      if (data_go) begin
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (tick) begin
        sample_cnt <= (sample_cnt == LAST_TICK) ? '0 : sample_cnt + 1'b1;
      end
      if (state == DATA && mid) begin
        data_sh <= {rx_sync, data_sh[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop     = valid_o & ready_i;
  assign do_push = push && ((count != FULL) || pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= {~rx_sync, pe_bit, data_sh};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overrun_o <= 1'b1;
      else if (clr_overrun_i) overrun_o <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign valid_o      = (count != '0);
  assign count_o      = count;
  assign busy_o       = (state != IDLE);
  assign data_o       = valid_o ? head[DATA_BITS-1:0] : '0;
  assign parity_err_o = valid_o & head[DATA_BITS];
  assign frame_err_o  = valid_o & head[DATA_BITS+1];

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 Parameter OVER_SAMPL, default 16: oversampling ticks per bit, even, 4..32.
REQ-004 Parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, 2..64.
REQ-005 Port clk_i, input, 1 bit: clock, rising-edge.
REQ-006 Port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 Port en_i, input, 1 bit: receiver enable; 0 forces IDLE, FIFO kept.
REQ-008 Port baud_div_i, input, 16 bits: oversample tick period minus one, in clk_i cycles.
REQ-009 Port parity_i, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 Port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-011 Port data_o, output, DATA_BITS bits: FIFO head data.
REQ-012 Port frame_err_o / parity_err_o, output, 1 bit each: error flags stored with the FIFO head.
REQ-013 Port valid_o, output, 1 bit: FIFO non-empty. Port ready_i, input, 1 bit: pop when valid_o & ready_i.
REQ-014 Port overrun_o, output, 1 bit: sticky overrun flag. Port clr_overrun_i, input, 1 bit: clears it.
REQ-015 Port busy_o, output, 1 bit: FSM not IDLE. Port count_o, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 rx_i SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-017 The tick counter SHALL count 0..baud_div_i and pulse tick for one cycle when equal to baud_div_i, then reload 0; baud_div_i=0 gives a tick every cycle.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a per-state tick counter runs 0..OVER_SAMPL-1.
REQ-019 IDLE->START on a synchronized falling edge while en_i=1; the tick counter clears.
REQ-020 In START, at tick OVER_SAMPL/2-1, the line SHALL be resampled: if low go to DATA with counters cleared; if high (glitch) return to IDLE with nothing pushed.
REQ-021 DATA SHALL sample LSB first, once every OVER_SAMPL ticks, DATA_BITS samples, then go to PARITY if parity is enabled, else to STOP.
REQ-022 PARITY SHALL sample one bit; parity_err SHALL be set on a mismatch against the XOR of the data bits (even: XOR==bit; odd: XOR!=bit).
REQ-023 STOP SHALL sample one bit; frame_err=1 if it is low; then {frame_err, parity_err, data} SHALL be pushed in the same cycle; FSM->IDLE.
REQ-024 A push while count_o==FIFO_DEPTH SHALL be dropped and set overrun_o; a simultaneous pop frees space first, so the push succeeds.
REQ-025 With simultaneous pop and push, count_o SHALL be unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 clr_overrun_i SHALL clear overrun_o next cycle; a new overrun in the same cycle wins (flag stays 1).
REQ-027 parity_i and baud_div_i SHALL be sampled only at IDLE->START and held for the frame.
REQ-028 en_i=0 mid-frame SHALL abort to IDLE next cycle with no push.
REQ-029 Frame latency: valid_o rises one cycle after the mid-stop sample if the FIFO was empty.

Reset
REQ-030 On rst_ni low: FSM IDLE, all counters 0, FIFO empty, valid_o=0, count_o=0, overrun_o=0, busy_o=0, frame_err_o=0, parity_err_o=0, data_o=0, synchronizer=1.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL need a new falling edge.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: PARITY state and parity_i decode present as above.
REQ-033 Macro UART_RX_PARITY_EN undefined: parity_i ignored, PARITY state never entered, parity_err_o tied 0, frame is start+DATA_BITS+stop.

Verification
REQ-034 Defaults, baud_div_i=0, parity none, send 0xA5 8N1 -> data_o=0xA5, errors 0, valid_o after ~154 cycles from the start edge.
REQ-035 parity_i=01, send 0x03 with parity bit 1 -> parity_err_o=1, data_o=0x03; same frame with parity bit 0 -> parity_err_o=0.
REQ-036 Send 0x55 with stop bit 0 -> frame_err_o=1, data_o=0x55, FSM returns to IDLE.
REQ-037 ready_i=0, send 9 frames with FIFO_DEPTH=8 -> count_o=8, overrun_o=1, the 9th is lost; pop order equals the first 8 sent; clr_overrun_i -> overrun_o=0.
REQ-038 Low pulse of 4 cycles at baud_div_i=0 -> returns to IDLE, nothing pushed; rst_ni pulse mid-DATA -> all outputs at reset values, next frame received correctly.
